// File: rtl/change_dispenser.sv
// Change dispenser: after a vend, pays saldo-PRICE one coin at a time (20/10/5),
// greedy largest-first against per-coin stock, then reports completion and any shortfall.
//
// state  | meaning
// IDLE   | waiting for vend; refill via load accepted here
// SELECT | pick the largest payable coin, or finish
// OFFER  | coin presented to ejector until coin_ack
// FINISH | done pulse, err valid
module change_dispenser #(
    parameter logic [5:0] PRICE  = 6'd40,
    parameter logic [3:0] INIT_N = 4'd8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_vend,
    input  logic [5:0] i_saldo,
    input  logic       i_load,
    input  logic [3:0] i_load_n20,
    input  logic [3:0] i_load_n10,
    input  logic [3:0] i_load_n5,
    output logic [4:0] o_coin,
    output logic       o_coin_valid,
    input  logic       i_coin_ack,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [3:0] o_n20,
    output logic [3:0] o_n10,
    output logic [3:0] o_n5
);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_OFFER, S_FINISH} state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_resto, w_resto_nxt;
    logic [4:0] r_coin, w_coin_nxt;
    logic       r_coin_valid, w_coin_valid_nxt;
    logic       r_done, w_done_nxt;
    logic       r_err, w_err_nxt;
    logic [3:0] r_n20, r_n10, r_n5;
    logic [3:0] w_n20_nxt, w_n10_nxt, w_n5_nxt;
    logic [4:0] w_pick;

    // Greedy choice; 0 means nothing payable (remainder 1..4 or stock exhausted)
    assign w_pick = (r_resto >= 6'd20 && r_n20 != 4'd0) ? 5'd20 :
                    (r_resto >= 6'd10 && r_n10 != 4'd0) ? 5'd10 :
                    (r_resto >= 6'd5  && r_n5  != 4'd0) ? 5'd5  : 5'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_vend) w_state_nxt = (i_saldo >= PRICE) ? S_SELECT : S_FINISH;
            S_SELECT: w_state_nxt = (r_resto != 6'd0 && w_pick != 5'd0) ? S_OFFER : S_FINISH;
            S_OFFER:  if (i_coin_ack) w_state_nxt = S_SELECT;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_resto_nxt      = r_resto;
        w_coin_nxt       = r_coin;
        w_coin_valid_nxt = r_coin_valid;
        w_done_nxt       = 1'b0;
        w_err_nxt        = r_err;
        w_n20_nxt        = r_n20;
        w_n10_nxt        = r_n10;
        w_n5_nxt         = r_n5;
        case (r_state)
            S_IDLE: begin
                if (i_vend) begin
                    if (i_saldo >= PRICE) begin
                        w_resto_nxt = i_saldo - PRICE;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_done_nxt = 1'b1;
                    end
                end else if (i_load) begin
                    w_n20_nxt = i_load_n20;
                    w_n10_nxt = i_load_n10;
                    w_n5_nxt  = i_load_n5;
                end
            end
            S_SELECT: begin
                if (r_resto == 6'd0) begin
                    w_done_nxt = 1'b1;
                    w_err_nxt  = 1'b0;
                end else if (w_pick != 5'd0) begin
                    w_coin_nxt       = w_pick;
                    w_coin_valid_nxt = 1'b1;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_resto_nxt = 6'd0;
                end
            end
            S_OFFER: begin
                if (i_coin_ack) begin
                    w_resto_nxt      = r_resto - {1'b0, r_coin};
                    w_coin_nxt       = 5'd0;
                    w_coin_valid_nxt = 1'b0;
                    case (r_coin)
                        5'd20:   w_n20_nxt = r_n20 - 4'd1;
                        5'd10:   w_n10_nxt = r_n10 - 4'd1;
                        5'd5:    w_n5_nxt  = r_n5 - 4'd1;
                        default: ;
                    endcase
                end
            end
            S_FINISH: begin
                w_err_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resto      <= 6'd0;
            r_coin       <= 5'd0;
            r_coin_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_n20        <= INIT_N;
            r_n10        <= INIT_N;
            r_n5         <= INIT_N;
        end else begin
            r_resto      <= w_resto_nxt;
            r_coin       <= w_coin_nxt;
            r_coin_valid <= w_coin_valid_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_n20        <= w_n20_nxt;
            r_n10        <= w_n10_nxt;
            r_n5         <= w_n5_nxt;
        end
    end

    assign o_coin       = r_coin;
    assign o_coin_valid = r_coin_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_n20        = r_n20;
    assign o_n10        = r_n10;
    assign o_n5         = r_n5;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin sequences, latency, stock, shortfall and reset.
module tb_change_dispenser;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_vend = 1'b0;
    logic [5:0] i_saldo = 6'd0;
    logic       i_load = 1'b0;
    logic [3:0] i_load_n20 = 4'd0;
    logic [3:0] i_load_n10 = 4'd0;
    logic [3:0] i_load_n5 = 4'd0;
    logic       i_coin_ack = 1'b0;
    logic [4:0] o_coin;
    logic       o_coin_valid;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [3:0] o_n20, o_n10, o_n5;

    int checks = 0;
    int errors = 0;
    int got_coins[$];
    int got_done;
    int got_err;

    change_dispenser dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_vend       (i_vend),
        .i_saldo      (i_saldo),
        .i_load       (i_load),
        .i_load_n20   (i_load_n20),
        .i_load_n10   (i_load_n10),
        .i_load_n5    (i_load_n5),
        .o_coin       (o_coin),
        .o_coin_valid (o_coin_valid),
        .i_coin_ack   (i_coin_ack),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_n20        (o_n20),
        .o_n10        (o_n10),
        .o_n5         (o_n5)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_load(input int a, input int b, input int c);
        i_load = 1'b1;
        i_load_n20 = 4'(a);
        i_load_n10 = 4'(b);
        i_load_n5 = 4'(c);
        tick();
        i_load = 1'b0;
    endtask

    // Vend, ack each coin in the cycle after it appears, stop at done
    task automatic run_vend(input int s);
        got_coins.delete();
        got_done = 0;
        got_err = 0;
        i_saldo = 6'(s);
        i_vend = 1'b1;
        tick();
        i_vend = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (o_done) begin
                got_done = 1;
                got_err = int'(o_err);
                break;
            end
            if (o_coin_valid && !i_coin_ack) begin
                got_coins.push_back(int'(o_coin));
                i_coin_ack = 1'b1;
            end else begin
                i_coin_ack = 1'b0;
            end
            tick();
        end
        i_coin_ack = 1'b0;
        chk("done_seen", got_done, 1);
        tick();
        chk("idle_after_done", int'(o_busy), 0);
    endtask

    initial begin
        tick();
        tick();
        i_rst = 1'b0;
        chk("rst_valid", int'(o_coin_valid), 0);
        chk("rst_coin", int'(o_coin), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_n20", int'(o_n20), 8);
        chk("rst_n10", int'(o_n10), 8);
        chk("rst_n5", int'(o_n5), 8);

        // ack outside OFFER must not disturb anything
        i_coin_ack = 1'b1;
        tick();
        i_coin_ack = 1'b0;
        chk("ack_idle_busy", int'(o_busy), 0);

        // 1: 55 -> change 15 = 10 + 5
        run_vend(55);
        chk("t1_ncoins", got_coins.size(), 2);
        if (got_coins.size() == 2) begin
            chk("t1_coin0", got_coins[0], 10);
            chk("t1_coin1", got_coins[1], 5);
        end
        chk("t1_err", got_err, 0);
        chk("t1_n20", int'(o_n20), 8);
        chk("t1_n10", int'(o_n10), 7);
        chk("t1_n5", int'(o_n5), 7);

        // 2: exact payment, latency of done
        i_saldo = 6'd40;
        i_vend = 1'b1;
        tick();
        i_vend = 1'b0;
        chk("t2_busy", int'(o_busy), 1);
        chk("t2_done_early", int'(o_done), 0);
        chk("t2_valid", int'(o_coin_valid), 0);
        tick();
        chk("t2_done", int'(o_done), 1);
        chk("t2_err", int'(o_err), 0);
        chk("t2_valid2", int'(o_coin_valid), 0);
        tick();
        chk("t2_done_off", int'(o_done), 0);
        chk("t2_idle", int'(o_busy), 0);

        // 3: no 20s in stock -> 10 + 10
        do_load(0, 8, 8);
        chk("t3_load_n20", int'(o_n20), 0);
        run_vend(60);
        chk("t3_ncoins", got_coins.size(), 2);
        if (got_coins.size() == 2) begin
            chk("t3_coin0", got_coins[0], 10);
            chk("t3_coin1", got_coins[1], 10);
        end
        chk("t3_err", got_err, 0);
        chk("t3_n10", int'(o_n10), 6);
        chk("t3_n5", int'(o_n5), 8);

        // 4: 63 -> 20 paid, remainder 3 unpayable
        do_load(8, 8, 8);
        run_vend(63);
        chk("t4_ncoins", got_coins.size(), 1);
        if (got_coins.size() == 1) chk("t4_coin0", got_coins[0], 20);
        chk("t4_err", got_err, 1);
        chk("t4_n20", int'(o_n20), 7);
        chk("t4_err_clr", int'(o_err), 0);

        // 5: ejector stalls; vend and load while busy are ignored
        i_saldo = 6'd60;
        i_vend = 1'b1;
        tick();
        i_vend = 1'b0;
        chk("t5_busy", int'(o_busy), 1);
        chk("t5_valid_early", int'(o_coin_valid), 0);
        tick();
        chk("t5_valid", int'(o_coin_valid), 1);
        chk("t5_coin", int'(o_coin), 20);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                i_saldo = 6'd63;
                i_vend = 1'b1;
            end
            if (c == 5) begin
                i_load = 1'b1;
                i_load_n20 = 4'd0;
                i_load_n10 = 4'd0;
                i_load_n5 = 4'd0;
            end
            tick();
            i_vend = 1'b0;
            i_load = 1'b0;
            chk("t5_hold_coin", int'(o_coin), 20);
            chk("t5_hold_valid", int'(o_coin_valid), 1);
            chk("t5_hold_busy", int'(o_busy), 1);
        end
        i_coin_ack = 1'b1;
        tick();
        i_coin_ack = 1'b0;
        chk("t5_ack_valid", int'(o_coin_valid), 0);
        chk("t5_ack_coin", int'(o_coin), 0);
        tick();
        chk("t5_done", int'(o_done), 1);
        chk("t5_err", int'(o_err), 0);
        chk("t5_n20", int'(o_n20), 6);
        chk("t5_n10", int'(o_n10), 8);
        tick();
        chk("t5_idle", int'(o_busy), 0);
        chk("t5_no_extra", int'(o_done), 0);

        // 6: balance below price, then reset during OFFER
        run_vend(30);
        chk("t6_ncoins", got_coins.size(), 0);
        chk("t6_err", got_err, 1);
        i_saldo = 6'd60;
        i_vend = 1'b1;
        tick();
        i_vend = 1'b0;
        tick();
        chk("t6_offer", int'(o_coin_valid), 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t6_rst_valid", int'(o_coin_valid), 0);
        chk("t6_rst_busy", int'(o_busy), 0);
        chk("t6_rst_done", int'(o_done), 0);
        chk("t6_rst_n20", int'(o_n20), 8);
        chk("t6_rst_n10", int'(o_n10), 8);
        chk("t6_rst_n5", int'(o_n5), 8);
        tick();
        chk("t6_post_done", int'(o_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
